// File: rtl/parity_frame_rx.sv
// parity_frame_rx: receive end of the XOR-parity serial link.
// Deserialises start | DATA_W data bits (LSB first) | parity | stop frames,
// checks parity and presents each word on a valid/ready output.
// Flags parity, framing and overrun errors.
// Optional feature: define PARITY_RX_ERR_CNT_EN to add the err_cnt[7:0] output.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
`ifdef PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              acc;

  logic              stop_strobe;
  logic              load;
  logic              drop;
  logic              ferr;
  logic              perr_new;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the FSM moves only on bit strobes.
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      unique case (state)
        IDLE:    if (!in) state_nxt = DATA;
        DATA:    if (bit_cnt == LAST) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame-completion decode: deliver, drop (overrun) or reject (framing).
  always_comb begin
    stop_strobe = (state == STOP) && in_valid;
    load        = stop_strobe && in && (!out_valid || out_ready);
    drop        = stop_strobe && in && out_valid && !out_ready;
    ferr        = stop_strobe && !in;
    perr_new    = (acc != ODD_PARITY);
  end

  // Deserialiser: bits enter at the MSB and shift right, so after DATA_W
  // strobes the first (LSB) bit sits at position 0 -- same as shift[bit_cnt]=in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      acc     <= 1'b0;
      shift   <= '0;
    end else if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (!in) begin
            bit_cnt <= '0;
            acc     <= 1'b0;
          end
        end
        DATA: begin
          shift   <= (shift >> 1) | (DATA_W'(in) << (DATA_W - 1));
          acc     <= acc ^ in;
          bit_cnt <= bit_cnt + CW'(1);
        end
        PARITY:  acc <= acc ^ in;
        default: ;
      endcase
    end
  end

  // Output register and valid/ready handshake; error pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= drop;
      if (load) begin
        out        <= shift;
        parity_err <= perr_new;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef PARITY_RX_ERR_CNT_EN
  // Saturating error counter; the three events are mutually exclusive per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (((load && perr_new) || ferr || drop) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: one even-parity and one odd-parity
// instance receive the same bit stream. Define PARITY_RX_ERR_CNT_EN to also
// check err_cnt.
module tb_parity_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       out_ready;

  logic [7:0] out_e, out_o;
  logic       ov_e, ov_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       ovr_e, ovr_o;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] ecnt_e, ecnt_o;
`endif

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in(sin), .in_valid(sin_valid),
    .out(out_e), .out_valid(ov_e), .out_ready(out_ready),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e)
`ifdef PARITY_RX_ERR_CNT_EN
    , .err_cnt(ecnt_e)
`endif
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .in(sin), .in_valid(sin_valid),
    .out(out_o), .out_valid(ov_o), .out_ready(out_ready),
    .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o)
`ifdef PARITY_RX_ERR_CNT_EN
    , .err_cnt(ecnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Expected word: {even-parity error flag, data}.
  logic [8:0] sb[$];

  int unsigned exp_ferr = 0, exp_ovr = 0;
  int unsigned seen_ferr_e = 0, seen_ferr_o = 0, seen_ovr_e = 0, seen_ovr_o = 0;
  int unsigned exp_err_e = 0, exp_err_o = 0;
  int unsigned pops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge: pop the scoreboard on each accepted word,
  // check hold-while-stalled, and count error pulses.
  logic       pv, pr;
  logic [7:0] pout;
  logic       pperr;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 32'(ov_e), 32'd1);
        check("hold_out", 32'(out_e), 32'(pout));
        check("hold_perr", 32'(perr_e), 32'(pperr));
      end
      if (ov_e && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", 32'(out_e), 32'h1ff);
        end else begin
          e = sb.pop_front();
          pops++;
          check("out_even", 32'(out_e), 32'(e[7:0]));
          check("perr_even", 32'(perr_e), 32'(e[8]));
          check("valid_odd", 32'(ov_o), 32'd1);
          check("out_odd", 32'(out_o), 32'(e[7:0]));
          check("perr_odd", 32'(perr_o), 32'(!e[8]));
        end
      end
      if (ferr_e) seen_ferr_e++;
      if (ferr_o) seen_ferr_o++;
      if (ovr_e)  seen_ovr_e++;
      if (ovr_o)  seen_ovr_o++;
      pv    = ov_e;
      pr    = out_ready;
      pout  = out_e;
      pperr = perr_e;
    end
  end

  task automatic strobe(input logic b, input int unsigned gap);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk); #1;
    sin_valid = 1'b0;
    sin       = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // expect_load=0 with stopb=1 means the frame should be dropped as an overrun.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input bit expect_load, input int unsigned gap);
    logic pe;
    pe = (^d) ^ pbit;
    if (stopb && expect_load) begin
      sb.push_back({pe, d});
      if (pe) exp_err_e++;
      else    exp_err_o++;
    end else if (stopb) begin
      exp_ovr++;
      exp_err_e++;
      exp_err_o++;
    end else begin
      exp_ferr++;
      exp_err_e++;
      exp_err_o++;
    end
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe(pbit, gap);
    strobe(stopb, gap);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ferr_e"}, seen_ferr_e, exp_ferr);
    check({tag, "_ferr_o"}, seen_ferr_o, exp_ferr);
    check({tag, "_ovr_e"}, seen_ovr_e, exp_ovr);
    check({tag, "_ovr_o"}, seen_ovr_o, exp_ovr);
    check({tag, "_sb_pending"}, 32'(sb.size()), 32'd0);
`ifdef PARITY_RX_ERR_CNT_EN
    check({tag, "_errcnt_e"}, 32'(ecnt_e), exp_err_e);
    check({tag, "_errcnt_o"}, 32'(ecnt_o), exp_err_o);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, 32'(out_e), 32'd0);
    check({tag, "_valid"}, 32'(ov_e), 32'd0);
    check({tag, "_perr"}, 32'(perr_e), 32'd0);
    check({tag, "_ferr"}, 32'(ferr_e), 32'd0);
    check({tag, "_ovr"}, 32'(ovr_e), 32'd0);
    check({tag, "_valid_o"}, 32'(ov_o), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    sin       = 1'b1;
    sin_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(2);

    // 1: clean even-parity frame, one-cycle valid
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    idle(1);
    check("t1_pops", pops, 32'd1);
    idle(1);
    check("t1_valid_low", 32'(ov_e), 32'd0);
    check_counts("t1");

    // 2: bad parity still delivered with parity_err
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    idle(3);
    check_counts("t2");

    // 3: framing error, then back-to-back good frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 0);
    idle(3);
    check("t3_pops", pops, 32'd3);
    check_counts("t3");

    // 4: stalled consumer, second frame overruns
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 0);
    idle(3);
    check("t4_out_held", 32'(out_e), 32'h3C);
    check("t4_valid_held", 32'(ov_e), 32'd1);
    check("t4_ovr", seen_ovr_e, exp_ovr);
    out_ready = 1'b1;
    idle(3);
    check("t4_valid_low", 32'(ov_e), 32'd0);
    check_counts("t4");

    // 5: gapped strobes; odd instance sees correct parity
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1);
    idle(3);
    check("t5_pops", pops, 32'd5);
    check_counts("t5");

    // 6: reset after the fourth data bit aborts the frame
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    rst_n = 1'b0;
    exp_err_e = 0;
    exp_err_o = 0;
    idle(2);
    check_reset_state("t6_reset");
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 0);
    idle(3);
    check("t6_pops", pops, 32'd6);
    check_counts("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
